// File: rtl/chunk_row_burst.sv
// Splits each row descriptor into vector-aligned DRAM read bursts of up to MAX_BURST vectors.
// Optional macro ROW_PREFETCH_EN: accept the next row in the cycle the final burst is acked.
module chunk_row_burst #(
  parameter int unsigned GBW       = 32,
  parameter int unsigned VSIZE     = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                                                   i_clk,
  input  logic                                                   i_rst,
  input  logic                                                   row_rdy,
  output logic                                                   row_ack,
  input  logic [GBW-1:0]                                         i_row_linear,
  input  logic                                                   i_row_islast,
  input  logic [$clog2(VSIZE)-1:0]                               i_row_pad,
  input  logic                                                   i_row_valid,
  input  logic [GBW-1:0]                                         i_row_len,
  output logic                                                   dramra_rdy,
  input  logic                                                   dramra_ack,
  output logic [GBW-$clog2(VSIZE)-1:0]                           o_dramra_addr,
  output logic [((MAX_BURST > 1) ? $clog2(MAX_BURST) : 1)-1:0]   o_dramra_len,
  output logic [$clog2(VSIZE)-1:0]                               o_dramra_ofs,
  output logic [$clog2(VSIZE)-1:0]                               o_dramra_pad,
  output logic                                                   o_dramra_fill,
  output logic                                                   o_dramra_islast
);

  localparam int unsigned V_BW  = $clog2(VSIZE);
  localparam int unsigned BL_BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned AW    = GBW - V_BW;
  localparam int unsigned SW    = GBW + 1;
  localparam int unsigned RW    = GBW + 1 - V_BW;
  localparam int unsigned NBW   = BL_BW + 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t             state_q, state_n;
  logic [AW-1:0]      vaddr_q, vaddr_n;
  logic [RW-1:0]      remain_q, remain_n;
  logic [BL_BW-1:0]   len_q, len_n;
  logic [V_BW-1:0]    ofs_q, ofs_n;
  logic [V_BW-1:0]    pad_q, pad_n;
  logic               fill_q, fill_n;
  logic               row_last_q, row_last_n;
  logic               islast_q, islast_n;
  logic               rdy_q, rdy_n;

  logic [V_BW-1:0]    row_ofs;
  logic [GBW-1:0]     row_len_eff;
  logic [SW-1:0]      row_sum;
  logic [RW-1:0]      row_remain;
  logic [NBW-1:0]     row_nb;
  logic [NBW-1:0]     cur_nb;
  logic [RW-1:0]      left;
  logic [NBW-1:0]     nxt_nb;
  logic               final_burst;

  // Vectors in the next burst: min(remaining vectors, MAX_BURST)
  function automatic logic [NBW-1:0] burst_of(input logic [RW-1:0] r);
    if (r <= RW'(MAX_BURST)) burst_of = NBW'(r);
    else                     burst_of = NBW'(MAX_BURST);
  endfunction

  // Row geometry; a zero length still yields one burst so islast is delivered
  always_comb begin
    row_ofs     = i_row_linear[V_BW-1:0];
    row_len_eff = (i_row_len == '0) ? GBW'(1) : i_row_len;
    row_sum     = SW'(row_ofs) + SW'(row_len_eff) + SW'(VSIZE - 1);
    row_remain  = RW'(row_sum >> V_BW);
    row_nb      = burst_of(row_remain);
    cur_nb      = burst_of(remain_q);
    left        = remain_q - RW'(cur_nb);
    nxt_nb      = burst_of(left);
    final_burst = (remain_q <= RW'(MAX_BURST));
  end

`ifdef ROW_PREFETCH_EN
  assign row_ack = row_rdy && !i_rst &&
                   ((state_q == IDLE) || ((state_q == ISSUE) && dramra_ack && final_burst));
`else
  assign row_ack = row_rdy && !i_rst && (state_q == IDLE);
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n    = state_q;
    vaddr_n    = vaddr_q;
    remain_n   = remain_q;
    len_n      = len_q;
    ofs_n      = ofs_q;
    pad_n      = pad_q;
    fill_n     = fill_q;
    row_last_n = row_last_q;
    islast_n   = islast_q;
    rdy_n      = rdy_q;

    case (state_q)
      IDLE: ;
      ISSUE: begin
        if (dramra_ack) begin
          vaddr_n  = vaddr_q + AW'(cur_nb);
          remain_n = left;
          if (final_burst) begin
            state_n = IDLE;
            rdy_n   = 1'b0;
          end else begin
            len_n    = BL_BW'(nxt_nb - NBW'(1));
            ofs_n    = '0;
            pad_n    = '0;
            islast_n = row_last_q && (left <= RW'(MAX_BURST));
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Row load overrides burst advance when a prefetched row arrives
    if (row_ack) begin
      state_n    = ISSUE;
      rdy_n      = 1'b1;
      vaddr_n    = i_row_linear[GBW-1:V_BW];
      remain_n   = row_remain;
      len_n      = BL_BW'(row_nb - NBW'(1));
      ofs_n      = row_ofs;
      pad_n      = i_row_pad;
      fill_n     = !i_row_valid;
      row_last_n = i_row_islast;
      islast_n   = i_row_islast && (row_remain <= RW'(MAX_BURST));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      vaddr_q    <= '0;
      remain_q   <= '0;
      len_q      <= '0;
      ofs_q      <= '0;
      pad_q      <= '0;
      fill_q     <= 1'b0;
      row_last_q <= 1'b0;
      islast_q   <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      vaddr_q    <= vaddr_n;
      remain_q   <= remain_n;
      len_q      <= len_n;
      ofs_q      <= ofs_n;
      pad_q      <= pad_n;
      fill_q     <= fill_n;
      row_last_q <= row_last_n;
      islast_q   <= islast_n;
      rdy_q      <= rdy_n;
    end
  end

  assign dramra_rdy      = rdy_q;
  assign o_dramra_addr   = vaddr_q;
  assign o_dramra_len    = len_q;
  assign o_dramra_ofs    = ofs_q;
  assign o_dramra_pad    = pad_q;
  assign o_dramra_fill   = fill_q;
  assign o_dramra_islast = islast_q;

endmodule

// File: doc/chunk_row_burst.md
Name: chunk_row_burst

Overview:
- Consumer end of the row rdy/ack channel produced by the chunk row-start stage.
- Takes one row descriptor per handshake: linear start, islast, pad, valid, row length.
- Breaks each row into vector-aligned DRAM read bursts and issues them on the dramra rdy/ack channel toward the DRAM read arbiter.
- Rows flagged invalid still produce the same burst sequence, marked fill, so the downstream collector's vector count is unchanged.

Parameters:
GBW, 32, global address width (TauCfg::GLOBAL_ADDR_BW)
VSIZE, 32, elements per vector; power of two; V_BW = $clog2(VSIZE)
MAX_BURST, 4, max vectors per burst; power of two ≥ 1; BL_BW = max($clog2(MAX_BURST),1)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; synchronous, active-high
row_rdy  in  1  row descriptor valid
row_ack  out  1  row descriptor accepted
i_row_linear  in  GBW  row start element address
i_row_islast  in  1  last row of chunk
i_row_pad  in  V_BW  pad element count for the row
i_row_valid  in  1  0: row out of bounds, fill instead of fetch
i_row_len  in  GBW  elements in row; static per chunk
dramra_rdy  out  1  burst command valid
dramra_ack  in  1  burst command accepted
o_dramra_addr  out  GBW-V_BW  vector address, i_row_linear>>V_BW plus vectors already issued
o_dramra_len  out  BL_BW  vectors in burst minus 1
o_dramra_ofs  out  V_BW  element offset in first vector; first burst of row only, else 0
o_dramra_pad  out  V_BW  latched pad; first burst of row only, else 0
o_dramra_fill  out  1  latched !i_row_valid
o_dramra_islast  out  1  latched islast AND final burst of row

Behaviour:
- FSM has two states, IDLE and ISSUE. Reset state is IDLE.
- Reset values: row_ack=0, dramra_rdy=0; all o_dramra_* registers cleared to 0.
- row_ack = row_rdy && state==IDLE. Combinational, zero-latency accept.
- On row_ack, latch the following and enter ISSUE; dramra_rdy rises the next cycle (1-cycle latency):
  - ofs = linear[V_BW-1:0]
  - vaddr = linear[GBW-1:V_BW]
  - pad, fill, islast, first=1
  - remain = (ofs + len + VSIZE-1) >> V_BW, computed in GBW+1 bits
- i_row_len==0 is treated as len 1, so exactly one burst is issued and islast is never lost.
- Burst size nb = min(remain, MAX_BURST). Output o_dramra_len = nb-1.
- In ISSUE, dramra_rdy=1 and all o_dramra_* hold stable until dramra_ack.
- On dramra_ack:
  - vaddr += nb; remain -= nb; first=0
  - if remain was ≤ MAX_BURST, go to IDLE and drop dramra_rdy next cycle
  - otherwise stay in ISSUE and present the next burst next cycle
- dramra_ack while dramra_rdy=0 is ignored.
- Fill rows issue the same addresses and lengths as a normal row, with fill=1.
- Address wrap at 2^(GBW-V_BW) is modular; no error is flagged.
- Row inputs are sampled only on the row_ack cycle; changes at other times are ignored.
- Reset mid-operation: i_rst wins over any simultaneous ack. State goes to IDLE, the in-flight row is discarded, and no partial burst is re-issued.

Optional Feature:
ROW_PREFETCH_EN
- Defined:
  - row_ack may also assert in ISSUE in the cycle where dramra_ack accepts a row's final burst.
  - The new row is latched that same cycle, and its first burst appears the next cycle with no bubble.
  - row_ack is still never asserted in any other ISSUE cycle.
- Undefined: row_ack only in IDLE, giving at least one idle cycle between a row's last burst and the next row's first burst.

Test Plan:
1. linear=0x40, len=64, valid=1, islast=1, dramra_ack tied 1 -> one burst: addr=2, len=1, ofs=0, fill=0, islast=1. FSM returns to IDLE.
2. linear=0x45, len=200, pad=3 -> 7 vectors issued as two bursts:
   - burst 1: addr=2, len=3, ofs=5, pad=3, islast=0
   - burst 2: addr=6, len=2, ofs=0, pad=0, islast=row islast
3. Same as 2 with valid=0 -> identical addr/len sequence with fill=1 on both bursts.
4. dramra_ack held 0 for 5 cycles during burst 1 with row_rdy=1 for the next row -> o_dramra_* constant and row_ack=0 throughout; sequence resumes unchanged on ack.
5. i_rst pulsed one cycle after the first burst of case 2 is acked -> next cycle dramra_rdy=0 and row_ack follows row_rdy; the second burst is never issued.
6. Back-to-back rows from case 1:
   - with ROW_PREFETCH_EN: row_ack coincides with the final dramra_ack and dramra_rdy stays high continuously
   - without ROW_PREFETCH_EN: exactly one cycle of dramra_rdy=0 between rows
